// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Includes the fetch-queue entry layout, the FSM state encoding and a PC alignment helper.
package ifu_fetch_pkg;

    localparam int unsigned PC_SIZE = 32;
    localparam logic [31:0] IFU_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_HALT  = 2'b11
    } ifu_state_e;

    typedef struct packed {
        logic [PC_SIZE-1:0] pc;
        logic [31:0]        ir;
        logic               err;
    } fq_entry_t;

    function automatic logic [PC_SIZE-1:0] pc_align(input logic [PC_SIZE-1:0] pc);
        return {pc[PC_SIZE-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fq.sv
// Small synchronous FIFO holding {pc, instruction, error} entries for decode.
// A clear may coincide with a push, in which case the pushed entry becomes the only entry.
module ifu_fq
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  fq_entry_t     push_data,
    output fq_entry_t     head_data,
    output logic [CW-1:0] count
);

    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] wr_idx_s;
    logic [CW-1:0] count_r;
    fq_entry_t     mem_r [DEPTH];

    // write slot: a clear restarts the ring at slot 0
    always_comb begin
        wr_idx_s = wr_ptr_r;
        if (clear) begin
            wr_idx_s = {AW{1'b0}};
        end else begin
            wr_idx_s = wr_ptr_r;
        end
    end

    // pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (clear) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= push ? AW'(1) : {AW{1'b0}};
            count_r  <= push ? CW'(1) : {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // entry storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '{pc: 32'h0000_0000, ir: 32'h0000_0000, err: 1'b0};
            end
        end else if (push) begin
            mem_r[wr_idx_s] <= push_data;
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: sequential PC generation, credit-limited memory requests, redirect handling.
// Optional misaligned-redirect trap enabled by defining CIRNO_IFU_MISALIGN_CHK_EN.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 2,
    parameter int unsigned MAX_OUTS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_req_valid,
    input  logic        i_req_ready,
    output logic [31:0] o_req_addr,
    input  logic        i_rsp_valid,
    input  logic [31:0] i_rsp_data,
    input  logic        i_rsp_err,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    output logic [31:0] o_ir,
    output logic [31:0] o_pc,
    output logic        o_ir_err,
    output logic        o_ir_valid,
    input  logic        i_dec_ready
);

    localparam int unsigned OW = $clog2(MAX_OUTS) + 1;
    localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

    logic          rst_n_q_r;
    ifu_state_e    state_r;
    ifu_state_e    state_nxt_s;
    ifu_state_e    flush_tgt_s;
    logic [31:0]   req_pc_r;
    logic [31:0]   rsp_pc_r;
    logic [OW-1:0] outs_r;
    logic [OW-1:0] outs_nxt_s;
    logic [OW-1:0] drop_r;
    logic [OW-1:0] drop_nxt_s;
    logic [CW-1:0] fq_count_s;
    logic          credit_s;
    logic          req_allow_s;
    logic          req_hs_s;
    logic          rsp_acc_s;
    logic          push_s;
    logic          pop_s;
    logic          misalign_s;
    fq_entry_t     push_data_s;
    fq_entry_t     head_s;

`ifdef CIRNO_IFU_MISALIGN_CHK_EN
    assign misalign_s = i_flush & (i_flush_pc[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    // request credit, handshakes and queue control
    always_comb begin
        credit_s    = ((32'(fq_count_s) + 32'(outs_r)) < 32'(FQ_DEPTH)) && (32'(outs_r) < 32'(MAX_OUTS));
        req_allow_s = rst_n_q_r && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
        o_req_valid = req_allow_s & credit_s & ~i_flush;
        req_hs_s    = o_req_valid & i_req_ready;
        // responses with nothing outstanding (e.g. left over from before reset) are ignored
        rsp_acc_s   = i_rsp_valid & rst_n_q_r & (outs_r != {OW{1'b0}});
        outs_nxt_s  = outs_r + OW'(req_hs_s) - OW'(rsp_acc_s);
        push_s      = (rsp_acc_s & (drop_r == {OW{1'b0}}) & ~i_flush) | misalign_s;
        pop_s       = o_ir_valid & i_dec_ready & ~i_flush;
        if (misalign_s) begin
            push_data_s = '{pc: i_flush_pc, ir: IFU_NOP, err: 1'b1};
        end else begin
            push_data_s = '{pc: rsp_pc_r, ir: i_rsp_data, err: i_rsp_err};
        end
    end

    // responses still in flight at a redirect become the drop budget
    always_comb begin
        drop_nxt_s = drop_r;
        if (i_flush) begin
            drop_nxt_s = outs_nxt_s;
        end else if (rsp_acc_s && (drop_r != {OW{1'b0}})) begin
            drop_nxt_s = drop_r - 1'b1;
        end else begin
            drop_nxt_s = drop_r;
        end
    end

    // fetch FSM next state
    always_comb begin
        state_nxt_s = state_r;
        if (misalign_s) begin
            flush_tgt_s = ST_HALT;
        end else if (drop_nxt_s != {OW{1'b0}}) begin
            flush_tgt_s = ST_DRAIN;
        end else begin
            flush_tgt_s = ST_RUN;
        end
        case (state_r)
            ST_RESET: state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (i_flush) begin
                    state_nxt_s = flush_tgt_s;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (i_flush) begin
                    state_nxt_s = misalign_s ? ST_HALT : ST_DRAIN;
                end else if (drop_nxt_s == {OW{1'b0}}) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
`ifdef CIRNO_IFU_MISALIGN_CHK_EN
            ST_HALT: begin
                if (i_flush) begin
                    state_nxt_s = flush_tgt_s;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
`endif
            default: state_nxt_s = ST_RESET;
        endcase
    end

    // control and PC registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_n_q_r <= 1'b0;
            state_r   <= ST_RESET;
            req_pc_r  <= RESET_PC;
            rsp_pc_r  <= RESET_PC;
            outs_r    <= {OW{1'b0}};
            drop_r    <= {OW{1'b0}};
        end else begin
            rst_n_q_r <= 1'b1;
            state_r   <= state_nxt_s;
            outs_r    <= outs_nxt_s;
            drop_r    <= drop_nxt_s;
            if (i_flush) begin
                req_pc_r <= pc_align(i_flush_pc);
                rsp_pc_r <= pc_align(i_flush_pc);
            end else begin
                if (req_hs_s) begin
                    req_pc_r <= req_pc_r + 32'd4;
                end
                if (push_s) begin
                    rsp_pc_r <= rsp_pc_r + 32'd4;
                end
            end
        end
    end

    ifu_fq #(
        .DEPTH(FQ_DEPTH)
    ) u_fq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (i_flush),
        .push     (push_s),
        .pop      (pop_s),
        .push_data(push_data_s),
        .head_data(head_s),
        .count    (fq_count_s)
    );

    assign o_req_addr = req_pc_r;
    assign o_ir_valid = (fq_count_s != {CW{1'b0}});
    assign o_ir       = head_s.ir;
    assign o_pc       = head_s.pc;
    assign o_ir_err   = head_s.err;

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: a transaction-level memory and fetch-queue model predict every output.
// Stale responses are tracked per request rather than by counters.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int FQ_DEPTH = 2;
    localparam int MAX_OUTS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        o_req_valid;
    logic        i_req_ready;
    logic [31:0] o_req_addr;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;
    logic        i_rsp_err;
    logic        i_flush;
    logic [31:0] i_flush_pc;
    logic [31:0] o_ir;
    logic [31:0] o_pc;
    logic        o_ir_err;
    logic        o_ir_valid;
    logic        i_dec_ready;

    always #5 clk = ~clk;

    ifu_fetch #(
        .RESET_PC(RESET_PC),
        .FQ_DEPTH(FQ_DEPTH),
        .MAX_OUTS(MAX_OUTS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .o_req_valid(o_req_valid),
        .i_req_ready(i_req_ready),
        .o_req_addr (o_req_addr),
        .i_rsp_valid(i_rsp_valid),
        .i_rsp_data (i_rsp_data),
        .i_rsp_err  (i_rsp_err),
        .i_flush    (i_flush),
        .i_flush_pc (i_flush_pc),
        .o_ir       (o_ir),
        .o_pc       (o_pc),
        .o_ir_err   (o_ir_err),
        .o_ir_valid (o_ir_valid),
        .i_dec_ready(i_dec_ready)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        err;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } mreq_t;

    ent_t        fq_m[$];
    mreq_t       mem_q[$];
    logic [31:0] exp_req_addr;
    bit          started;
    bit          halted;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // word at 0x8 (and every 7th word after) carries a bus error
    function automatic logic mem_err(input logic [31:0] addr);
        return ((addr >> 2) % 32'd7) == 32'd2;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        i_flush     = 1'b0;
        i_flush_pc  = 32'h0000_0000;
        i_req_ready = 1'b1;
        i_dec_ready = 1'b1;
        i_rsp_valid = 1'b1;
        i_rsp_data  = 32'hDEAD_BEEF;
        i_rsp_err   = 1'b0;
        started      = 1'b0;
        halted       = 1'b0;
        exp_req_addr = RESET_PC;
        mem_q.delete();
        fq_m.delete();
        repeat (2) @(negedge clk);
        check_val("rst_req_valid", 32'(o_req_valid), 32'd0);
        check_val("rst_req_addr", o_req_addr, RESET_PC);
        check_val("rst_ir_valid", 32'(o_ir_valid), 32'd0);
        check_val("rst_ir", o_ir, 32'd0);
        check_val("rst_pc", o_pc, 32'd0);
        check_val("rst_ir_err", 32'(o_ir_err), 32'd0);
        // stray response during the release cycle must be ignored
        rst_n = 1'b1;
        #1;
        check_val("req_first_cycle", 32'(o_req_valid), 32'd0);
        started = 1'b1;
    endtask

    task automatic run_cycle(input int p_rdy, input int p_rsp, input int p_dec, input int p_flush);
        bit          fl;
        bit          rv;
        bit          hs;
        bit          pop;
        bit          exp_v;
        logic [31:0] fpc;
        logic [1:0]  flo;
        mreq_t       m;
        @(negedge clk);
        check_val("ir_valid", 32'(o_ir_valid), 32'(fq_m.size() != 0));
        if (fq_m.size() != 0) begin
            check_val("o_pc", o_pc, fq_m[0].pc);
            check_val("o_ir", o_ir, fq_m[0].ir);
            check_val("o_ir_err", 32'(o_ir_err), 32'(fq_m[0].err));
        end
        fl = ($urandom_range(99) < p_flush);
        case ($urandom_range(3))
            0:       fpc = 32'h0000_0100;
            1:       fpc = 32'hFFFF_FFF8;
            2:       fpc = $urandom & 32'hFFFF_FFFC;
            default: fpc = $urandom;
        endcase
        i_flush     = fl;
        i_flush_pc  = fpc;
        i_req_ready = ($urandom_range(99) < p_rdy);
        i_dec_ready = ($urandom_range(99) < p_dec);
        rv = (mem_q.size() != 0) && ($urandom_range(99) < p_rsp);
        i_rsp_valid = rv;
        if (rv) begin
            i_rsp_data = mem_word(mem_q[0].addr);
            i_rsp_err  = mem_err(mem_q[0].addr);
        end else begin
            i_rsp_data = $urandom;
            i_rsp_err  = $urandom_range(1);
        end
        #1;
        exp_v = started && !fl && !halted && ((fq_m.size() + mem_q.size()) < FQ_DEPTH)
                && (mem_q.size() < MAX_OUTS);
        check_val("req_valid", 32'(o_req_valid), 32'(exp_v));
        if (exp_v) begin
            check_val("req_addr", o_req_addr, exp_req_addr);
        end
        hs  = exp_v && i_req_ready;
        pop = (fq_m.size() != 0) && i_dec_ready && !fl;
        if (rv) begin
            m = mem_q.pop_front();
        end
        if (pop) begin
            void'(fq_m.pop_front());
        end
        if (rv && !m.stale && !fl) begin
            fq_m.push_back('{m.addr, mem_word(m.addr), mem_err(m.addr)});
        end
        if (hs) begin
            mem_q.push_back('{exp_req_addr, 1'b0});
            exp_req_addr = exp_req_addr + 32'd4;
        end
        if (fl) begin
            fq_m.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            exp_req_addr = {fpc[31:2], 2'b00};
            halted = 1'b0;
            flo = fpc[1:0];
`ifdef CIRNO_IFU_MISALIGN_CHK_EN
            if (flo != 2'b00) begin
                fq_m.push_back('{fpc, 32'h0000_0013, 1'b1});
                halted = 1'b1;
            end
`endif
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        i_req_ready = 1'b0;
        i_rsp_valid = 1'b0;
        i_rsp_data  = 32'h0000_0000;
        i_rsp_err   = 1'b0;
        i_flush     = 1'b0;
        i_flush_pc  = 32'h0000_0000;
        i_dec_ready = 1'b0;
        do_reset();
        repeat (30) run_cycle(100, 100, 100, 0);
        repeat (15) run_cycle(100, 100, 0, 0);
        repeat (10) run_cycle(0, 100, 100, 0);
        repeat (2000) run_cycle(70, 60, 60, 5);
        repeat (300) run_cycle(100, 100, 100, 10);
        do_reset();
        repeat (500) run_cycle(50, 50, 70, 8);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
